// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator.
// Next-PC source encodings and mode width.
package pc_gen_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JREG   = 2'b10,
        PC_RET    = 2'b11
    } pcMode_t;

endpackage

// File: rtl/pc_gen_ras_ret_addr_stack.sv
// Circular hardware return-address stack with sticky overflow/underflow.
// A full push overwrites the oldest entry; an empty pop reports underflow.
module ret_addr_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       Enable,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic [WIDTH-1:0]           LinkIn,
    input  logic                       ErrClear,
    output logic [WIDTH-1:0]           Top,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    topPtr, nextPtr, wrPtr;
    logic [CW-1:0]    count, nextCount;
    logic             wrEn, ovfEvent, unfEvent;
    logic             doPush, doPop;

    assign doPush = Enable & Push;
    assign doPop  = Enable & Pop;
    assign Empty  = (count == '0);
    assign Full   = (count == CW'(DEPTH));
    assign Count  = count;
    assign Top    = mem[topPtr];

    always_comb begin
        nextPtr   = topPtr;
        nextCount = count;
        wrEn      = 1'b0;
        wrPtr     = topPtr;
        ovfEvent  = 1'b0;
        unfEvent  = 1'b0;
        if (doPush && doPop) begin
            wrEn = 1'b1;
            if (Empty) begin
                unfEvent  = 1'b1;
                wrPtr     = topPtr + 1'b1;
                nextPtr   = topPtr + 1'b1;
                nextCount = CW'(1);
            end
        end else if (doPush) begin
            wrEn    = 1'b1;
            wrPtr   = topPtr + 1'b1;
            nextPtr = topPtr + 1'b1;
            if (Full) ovfEvent = 1'b1;
            else nextCount = count + 1'b1;
        end else if (doPop) begin
            if (Empty) begin
                unfEvent = 1'b1;
            end else begin
                nextPtr   = topPtr - 1'b1;
                nextCount = count - 1'b1;
            end
        end
    end

    // Storage needs no reset; count alone decides what is valid.
    always_ff @(posedge Clock) begin
        if (wrEn) mem[wrPtr] <= LinkIn;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            topPtr    <= '0;
            count     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (Enable) begin
            topPtr    <= nextPtr;
            count     <= nextCount;
            Overflow  <= (Overflow & ~ErrClear) | ovfEvent;
            Underflow <= (Underflow & ~ErrClear) | unfEvent;
        end
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch-stage PC generator: next-PC mux, PC/PC_temp registers,
// misalignment flag, and a return-address stack for calls/returns.
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          RAS_DEPTH  = 8,
    parameter logic [31:0] RESET_ADDR = 32'h0,
    parameter int          INC        = 4
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic                        PC_enable,
    input  logic [MODE_W-1:0]           PC_mode,
    input  logic                        Call,
    input  logic [WIDTH-1:0]            BranchOff,
    input  logic [WIDTH-1:0]            RA,
    input  logic                        Err_clear,
    output logic [WIDTH-1:0]            PC,
    output logic [WIDTH-1:0]            PC_temp,
    output logic [WIDTH-1:0]            Link,
    output logic [$clog2(RAS_DEPTH):0]  RAS_count,
    output logic                        RAS_empty,
    output logic                        RAS_full,
    output logic                        Overflow,
    output logic                        Underflow,
    output logic                        Misalign
);

    pcMode_t          mode;
    logic [WIDTH-1:0] nextPc, rasTop, branchTgt, retTgt;
    logic             isRet;

    assign mode      = pcMode_t'(PC_mode);
    assign isRet     = (mode == PC_RET);
    assign Link      = PC + WIDTH'(INC);
    assign branchTgt = PC + BranchOff;
    assign retTgt    = RAS_empty ? RA : rasTop;

    always_comb begin
        nextPc = Link;
        unique case (mode)
            PC_SEQ:    nextPc = Link;
            PC_BRANCH: nextPc = branchTgt;
            PC_JREG:   nextPc = RA;
            PC_RET:    nextPc = retTgt;
            default:   nextPc = Link;
        endcase
    end

    ret_addr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) uRas (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Enable    (PC_enable),
        .Push      (Call),
        .Pop       (isRet),
        .LinkIn    (Link),
        .ErrClear  (Err_clear),
        .Top       (rasTop),
        .Count     (RAS_count),
        .Empty     (RAS_empty),
        .Full      (RAS_full),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            PC       <= WIDTH'(RESET_ADDR);
            PC_temp  <= WIDTH'(RESET_ADDR);
            Misalign <= 1'b0;
        end else if (PC_enable) begin
            PC       <= nextPc;
            PC_temp  <= PC;
            Misalign <= (Misalign & ~Err_clear) | (nextPc[1:0] != 2'b00);
        end
    end

endmodule
